// File: rtl/seg7_capture.sv
// seg7_capture: recovers a 4-digit frame from multiplexed 7-segment drive lines.
// The segment and digit-strobe inputs are synchronized, then debounced by a stability counter.
// Each stable digit is decoded into a 4-bit code and stored in its slot.
// Once all four slots are filled, the collected codes are handed off as one frame
// using a valid/ready handshake.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  dsel,
    output logic [15:0] frame,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [6:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [3:0]  dsel_s1_q, dsel_s1_d, dsel_s2_q, dsel_s2_d;
    logic [10:0] prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        captured_q, captured_d;
    logic [15:0] slot_q, slot_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] frame_q, frame_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_valid_q, frame_valid_d;
    logic        overrun_q, overrun_d;

    logic [10:0] cur;
    logic        onehot;
    logic        changed;
    logic        capture;
    logic        complete;
    logic [3:0]  code;
    logic        bad;

    // Synchronizers, stability counter and the one-shot capture flag
    always_comb begin
        seg_s1_d  = seg;
        seg_s2_d  = seg_s1_q;
        dsel_s1_d = dsel;
        dsel_s2_d = dsel_s1_q;
        cur       = {dsel_s2_q, seg_s2_q};
        prev_d    = cur;
        onehot    = (dsel_s2_q != 4'd0) && ((dsel_s2_q & (dsel_s2_q - 4'd1)) == 4'd0);
        changed   = (cur != prev_q);
        if (!onehot)
            cnt_d = 8'd0;
        else if (changed)
            cnt_d = 8'd1;
        else if (cnt_q < STABLE)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = cnt_q;
        // cnt_q == STABLE implies prev_q holds the stable, one-hot value just counted
        capture    = (cnt_q == STABLE) && !captured_q;
        captured_d = (!onehot || changed) ? 1'b0 : (captured_q | capture);
    end

    // Segment pattern decode of the value being captured (held in prev_q)
    always_comb begin
        bad = 1'b0;
        unique case (prev_q[6:0])
            7'b1111110: code = 4'h0;
            7'b0110000: code = 4'h1;
            7'b1101101: code = 4'h2;
            7'b1111001: code = 4'h3;
            7'b0110011: code = 4'h4;
            7'b1011011: code = 4'h5;
            7'b1011111: code = 4'h6;
            7'b1110000: code = 4'h7;
            7'b1111111: code = 4'h8;
            7'b1111011: code = 4'h9;
            7'b0000001: code = 4'hA;
            7'b0001110: code = 4'hB;
            7'b1001110: code = 4'hC;
            7'b1000110: code = 4'hD;
            7'b1001111: code = 4'hE;
            7'b0000000: code = 4'hF;
            default: begin
                code = 4'hF;
                bad  = 1'b1;
            end
        endcase
    end

    // Slot store and frame handoff; a capture on the completion edge starts the next frame
    always_comb begin
        complete      = (mask_q == 4'hF);
        slot_d        = slot_q;
        err_d         = complete ? 4'd0 : err_q;
        mask_d        = complete ? 4'd0 : mask_q;
        frame_d       = frame_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (prev_q[7+i]) begin
                    slot_d[i*4 +: 4] = code;
                    err_d[i]         = bad;
                    mask_d[i]        = 1'b1;
                end
            end
        end
        if (complete) begin
            frame_d       = slot_q;
            frame_err_d   = |err_q;
            frame_valid_d = 1'b1;
            // Replacing a frame the consumer has not taken is an overrun
            overrun_d     = overrun_q | (frame_valid_q & ~frame_ready);
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q      <= '0;
            seg_s2_q      <= '0;
            dsel_s1_q     <= '0;
            dsel_s2_q     <= '0;
            prev_q        <= '0;
            cnt_q         <= '0;
            captured_q    <= 1'b0;
            slot_q        <= '0;
            err_q         <= '0;
            mask_q        <= '0;
            frame_q       <= '0;
            frame_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            seg_s1_q      <= seg_s1_d;
            seg_s2_q      <= seg_s2_d;
            dsel_s1_q     <= dsel_s1_d;
            dsel_s2_q     <= dsel_s2_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            captured_q    <= captured_d;
            slot_q        <= slot_d;
            err_q         <= err_d;
            mask_q        <= mask_d;
            frame_q       <= frame_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign frame       = frame_q;
    assign frame_err   = frame_err_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (STABLE_CYCLES = 4).
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = '0;
    logic [3:0]  dsel = '0;
    logic [15:0] frame;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic        frame_err;
    logic        overrun;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          vcount = 0;
    logic [15:0] last_frame = '0;
    logic        last_err = 1'b0;

    seg7_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dsel(dsel), .frame(frame),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Segment pattern {abcdefg} for a digit code
    function automatic logic [6:0] pat(input int c);
        case (c)
            0: pat = 7'b1111110;  1: pat = 7'b0110000;  2: pat = 7'b1101101;
            3: pat = 7'b1111001;  4: pat = 7'b0110011;  5: pat = 7'b1011011;
            6: pat = 7'b1011111;  7: pat = 7'b1110000;  8: pat = 7'b1111111;
            9: pat = 7'b1111011;  default: pat = 7'b0000000;
        endcase
    endfunction

    // Step n clocks, sampling outputs 1 time unit after each rising edge
    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (frame_valid) begin
                vcount++;
                last_frame = frame;
                last_err   = frame_err;
            end
        end
    endtask

    task automatic show(input int d, input logic [6:0] p, input int n);
        dsel = 4'b0001 << d;
        seg  = p;
        hold(n);
    endtask

    // Scan digits 0..3 showing codes c0..c3, then blank the display
    task automatic scan4(input int c0, input int c1, input int c2, input int c3);
        show(0, pat(c0), 10);
        show(1, pat(c1), 10);
        show(2, pat(c2), 10);
        show(3, pat(c3), 10);
        dsel = '0; seg = '0;
        hold(4);
    endtask

    task automatic do_reset();
        rst = 1'b1; dsel = '0; seg = '0;
        hold(3);
        rst = 1'b0;
        hold(1);
        vcount = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hold(3);
        n_cmp++; if (frame !== 16'h0000) begin n_bad++; $display("FAIL reset_frame got %h want 0000", frame); end
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", frame_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst = 1'b0;
        hold(1);
        vcount = 0;
    endtask

    task automatic test_basic_scan();
        vcount = 0;
        scan4(1, 2, 3, 4);
        hold(5);
        n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL basic_pulses got %0d want 1", vcount); end
        n_cmp++; if (last_frame !== 16'h4321) begin n_bad++; $display("FAIL basic_frame got %h want 4321", last_frame); end
        n_cmp++; if (last_err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", last_err); end
    endtask

    task automatic test_unmapped();
        vcount = 0;
        show(0, pat(8), 10);
        show(1, pat(8), 10);
        show(2, 7'b1010101, 10);
        show(3, pat(8), 10);
        dsel = '0; seg = '0;
        hold(6);
        n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL unmapped_pulses got %0d want 1", vcount); end
        n_cmp++; if (last_frame !== 16'h8F88) begin n_bad++; $display("FAIL unmapped_frame got %h want 8f88", last_frame); end
        n_cmp++; if (last_err !== 1'b1) begin n_bad++; $display("FAIL unmapped_err got %b want 1", last_err); end
    endtask

    // Digit 3 held 3 cycles must not capture; held exactly 4 cycles must
    task automatic test_glitch();
        vcount = 0;
        show(0, pat(5), 10);
        show(1, pat(6), 10);
        show(2, pat(7), 10);
        show(3, pat(9), 3);
        dsel = '0; seg = '0;
        hold(15);
        n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL glitch_nocap got %0d pulses want 0", vcount); end
        show(3, pat(9), 4);
        dsel = '0; seg = '0;
        hold(10);
        n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL glitch_exact_pulses got %0d want 1", vcount); end
        n_cmp++; if (last_frame !== 16'h9765) begin n_bad++; $display("FAIL glitch_frame got %h want 9765", last_frame); end
    endtask

    task automatic test_multi_hot();
        vcount = 0;
        dsel = 4'b0011; seg = pat(8);
        hold(20);
        show(0, pat(1), 10);
        show(2, pat(5), 10);
        show(3, pat(7), 10);
        dsel = '0; seg = '0;
        hold(6);
        n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL multihot_nocap got %0d pulses want 0", vcount); end
        show(1, pat(0), 10);
        dsel = '0; seg = '0;
        hold(6);
        n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL multihot_pulses got %0d want 1", vcount); end
        n_cmp++; if (last_frame !== 16'h7501) begin n_bad++; $display("FAIL multihot_frame got %h want 7501", last_frame); end
    endtask

    task automatic test_overrun();
        frame_ready = 1'b0;
        vcount = 0;
        scan4(4, 3, 2, 1);
        hold(3);
        n_cmp++; if (frame_valid !== 1'b1 || frame !== 16'h1234) begin n_bad++; $display("FAIL ovr_first got v=%b %h want v=1 1234", frame_valid, frame); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_first_flag got %b want 0", overrun); end
        scan4(8, 7, 6, 5);
        hold(3);
        n_cmp++; if (frame_valid !== 1'b1 || frame !== 16'h5678) begin n_bad++; $display("FAIL ovr_second got v=%b %h want v=1 5678", frame_valid, frame); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", overrun); end
        frame_ready = 1'b1;
        hold(1);
        frame_ready = 1'b0;
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_accept got %b want 0", frame_valid); end
        hold(3);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        frame_ready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        show(0, pat(3), 10);
        show(1, pat(3), 10);
        show(2, pat(3), 10);
        dsel = '0; seg = '0;
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
        vcount = 0;
        show(3, pat(9), 10);
        dsel = '0; seg = '0;
        hold(20);
        n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL rstmid_nocap got %0d pulses want 0", vcount); end
        scan4(6, 7, 8, 9);
        hold(3);
        n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL rstmid_pulses got %0d want 1", vcount); end
        n_cmp++; if (last_frame !== 16'h9876) begin n_bad++; $display("FAIL rstmid_frame got %h want 9876", last_frame); end
    endtask

    // New frame completes on the same edge the pending one is accepted
    task automatic test_back_to_back();
        do_reset();
        frame_ready = 1'b0;
        scan4(1, 2, 3, 4);
        show(0, pat(5), 10);
        show(1, pat(6), 10);
        show(2, pat(7), 10);
        // Capture lands on the 7th edge, completion on the 8th
        show(3, pat(8), 7);
        n_cmp++; if (frame !== 16'h4321 || frame_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_pending got v=%b %h want v=1 4321", frame_valid, frame); end
        frame_ready = 1'b1;
        hold(1);
        frame_ready = 1'b0;
        n_cmp++; if (frame_valid !== 1'b1 || frame !== 16'h8765) begin n_bad++; $display("FAIL b2b_load got v=%b %h want v=1 8765", frame_valid, frame); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", overrun); end
        dsel = '0; seg = '0;
        hold(4);
        n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_hold got %b want 1", frame_valid); end
        frame_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_unmapped();
        test_glitch();
        test_multi_hot();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive cycles a synchronized {dsel, seg} value must hold before capture.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 seg  input  7  segment lines {a,b,c,d,e,f,g}, active-high, asynchronous to clk.
REQ-005 dsel  input  4  digit strobes, one-hot active-high (bit i = digit i), asynchronous to clk.
REQ-006 frame  output  16  recovered codes; nibble i = digit i.
REQ-007 frame_valid  output  1  frame holds a complete capture.
REQ-008 frame_ready  input  1  consumer accepts frame.
REQ-009 frame_err  output  1  at least one digit in frame had an unmapped pattern; qualified by frame_valid.
REQ-010 overrun  output  1  sticky: a completed frame was overwritten before acceptance.

Function
REQ-011 seg and dsel SHALL each pass through a 2-flop synchronizer; all further logic uses synchronized values only.
REQ-012 The block SHALL keep a stability counter, saturating at STABLE_CYCLES, that resets to 1 on any cycle whose synchronized {dsel, seg} differs from the previous cycle's value and increments otherwise.
REQ-013 The counter SHALL be held at 0 while synchronized dsel is not one-hot (zero or multiple bits); no capture occurs in that state.
REQ-014 Capture SHALL occur exactly once per stable period, on the cycle the counter first reaches STABLE_CYCLES; no recapture until the value changes.
REQ-015 Pattern-to-code map {abcdefg} SHALL be: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9, 0000001->A ('-'), 0001110->B ('L'), 1001110->C ('C'), 1000110->D ('r'), 1001111->E ('E'), 0000000->F (blank).
REQ-016 An unmapped pattern SHALL store code F in the slot and set that slot's error bit.
REQ-017 Capture of digit i SHALL write slot i and its error bit and set mask bit i; recapture of an already-masked digit overwrites the slot.
REQ-018 When the mask becomes 1111, on the following edge the block SHALL load frame and frame_err (OR of the four error bits), assert frame_valid, and clear mask and error bits.
REQ-019 frame_valid SHALL stay high, and frame/frame_err stable, until a cycle with frame_valid and frame_ready both high; frame_valid deasserts on the next edge.
REQ-020 If a new frame completes while frame_valid is high and frame_ready is low, frame/frame_err SHALL be replaced, frame_valid stays high, and overrun SHALL set.
REQ-021 If a completion coincides with acceptance, the new frame SHALL load, frame_valid stays high, and overrun SHALL NOT set.
REQ-022 Latency: from a {dsel, seg} input change held steady, capture SHALL occur on edge 2+STABLE_CYCLES after the first edge that samples the new value.

Reset
REQ-023 While rst is high: synchronizers, counter, slots, mask and error bits clear; frame=0x0000, frame_valid=0, frame_err=0, overrun=0.
REQ-024 Reset asserted mid-frame SHALL discard partial captures; overrun clears only on reset.

Verification
REQ-025 Scan digits 0..3 with patterns for 1,2,3,4, each held 10 cycles -> one frame_valid pulse, frame=0x4321, frame_err=0.
REQ-026 Digit 2 shows 1010101, others valid 8 -> frame=0x8F88, frame_err=1.
REQ-027 Glitch: pattern held STABLE_CYCLES-1 cycles then changed -> no capture, mask unchanged.
REQ-028 dsel=0011 held 20 cycles -> no capture; then dsel=0001 with 0110000 held -> slot 0 = 1.
REQ-029 frame_ready low, two full scans (0x1234 then 0x5678) -> frame=0x5678, overrun=1; ready high one cycle -> frame_valid drops next edge, overrun stays 1.
REQ-030 rst pulse after digits 0..2 captured, then only digit 3 scanned -> no frame_valid; full scan afterwards -> frame_valid with new values.
